// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
//   Stage 1 registers the operands and opcode; stage 2 registers the result and
//   status flags computed combinationally from stage 1. Sustains one op/cycle
//   and holds up to two operations when the consumer stalls.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_valid / o_ready   input handshake (o_ready depends on i_ready, never on i_valid)
//   i_ope1, i_ope2      signed operands; i_ope2 is the unsigned shift amount for shifts
//   i_opcode            operation select
//   o_valid / i_ready   output handshake
//   o_result            result
//   o_zero, o_neg       result == 0, result MSB
//   o_carry, o_ovf      ADD carry / SUB borrow, signed overflow (ADD/SUB only)
//   o_err               opcode not recognised (result forced to 0)
module alu_pipe #(
  parameter int BUS_LEN    = 8,
  parameter int OPCODE_LEN = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [BUS_LEN-1:0]    i_ope1,
  input  logic [BUS_LEN-1:0]    i_ope2,
  input  logic [OPCODE_LEN-1:0] i_opcode,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [BUS_LEN-1:0]    o_result,
  output logic                  o_zero,
  output logic                  o_neg,
  output logic                  o_carry,
  output logic                  o_ovf,
  output logic                  o_err
);

  localparam int M = BUS_LEN - 1;

  localparam logic [OPCODE_LEN-1:0] OP_SLL  = OPCODE_LEN'(6'b000000);
  localparam logic [OPCODE_LEN-1:0] OP_SRL  = OPCODE_LEN'(6'b000010);
  localparam logic [OPCODE_LEN-1:0] OP_SRA  = OPCODE_LEN'(6'b000011);
  localparam logic [OPCODE_LEN-1:0] OP_ADD  = OPCODE_LEN'(6'b100000);
  localparam logic [OPCODE_LEN-1:0] OP_SUB  = OPCODE_LEN'(6'b100010);
  localparam logic [OPCODE_LEN-1:0] OP_AND  = OPCODE_LEN'(6'b100100);
  localparam logic [OPCODE_LEN-1:0] OP_OR   = OPCODE_LEN'(6'b100101);
  localparam logic [OPCODE_LEN-1:0] OP_XOR  = OPCODE_LEN'(6'b100110);
  localparam logic [OPCODE_LEN-1:0] OP_NOR  = OPCODE_LEN'(6'b100111);
  localparam logic [OPCODE_LEN-1:0] OP_SLT  = OPCODE_LEN'(6'b101010);
  localparam logic [OPCODE_LEN-1:0] OP_SLTU = OPCODE_LEN'(6'b101011);

  typedef struct packed {
    logic [BUS_LEN-1:0]    a;
    logic [BUS_LEN-1:0]    b;
    logic [OPCODE_LEN-1:0] op;
  } s1_t;

  typedef struct packed {
    logic [BUS_LEN-1:0] res;
    logic               zero;
    logic               neg;
    logic               carry;
    logic               ovf;
    logic               err;
  } out_t;

  logic   r_s1_valid;
  s1_t    r_s1;
  logic   r_o_valid;
  out_t   r_out;

  logic   w_in_hs;
  logic   w_adv2;
  out_t   w_out;
  logic [BUS_LEN:0]   w_sum;
  logic [BUS_LEN:0]   w_dif;
  logic [BUS_LEN-1:0] w_shamt;

  // Handshake / advance control
  assign w_adv2  = r_s1_valid && (!r_o_valid || i_ready);
  assign o_ready = !rst && (!r_s1_valid || w_adv2);
  assign w_in_hs = i_valid && o_ready;

  // Extra MSB of the unsigned sum is the carry; of the unsigned difference, the borrow.
  assign w_sum   = {1'b0, r_s1.a} + {1'b0, r_s1.b};
  assign w_dif   = {1'b0, r_s1.a} - {1'b0, r_s1.b};
  assign w_shamt = r_s1.b % BUS_LEN'(BUS_LEN);

  always_comb begin
    w_out = '0;
    case (r_s1.op)
      OP_ADD: begin
        w_out.res   = w_sum[M:0];
        w_out.carry = w_sum[BUS_LEN];
        w_out.ovf   = (r_s1.a[M] == r_s1.b[M]) && (w_sum[M] != r_s1.a[M]);
      end
      OP_SUB: begin
        w_out.res   = w_dif[M:0];
        w_out.carry = w_dif[BUS_LEN];
        w_out.ovf   = (r_s1.a[M] != r_s1.b[M]) && (w_dif[M] != r_s1.a[M]);
      end
      OP_AND:  w_out.res = r_s1.a & r_s1.b;
      OP_OR:   w_out.res = r_s1.a | r_s1.b;
      OP_XOR:  w_out.res = r_s1.a ^ r_s1.b;
      OP_NOR:  w_out.res = ~(r_s1.a | r_s1.b);
      OP_SRA:  w_out.res = $signed(r_s1.a) >>> w_shamt;
      OP_SRL:  w_out.res = r_s1.a >> w_shamt;
      OP_SLL:  w_out.res = r_s1.a << w_shamt;
      OP_SLT:  w_out.res = {{M{1'b0}}, ($signed(r_s1.a) < $signed(r_s1.b))};
      OP_SLTU: w_out.res = {{M{1'b0}}, (r_s1.a < r_s1.b)};
      default: w_out.err = 1'b1;
    endcase
    w_out.zero = (w_out.res == '0);
    w_out.neg  = w_out.res[M];
  end

  // Stage 1: a new accept takes priority; it can coincide with s1 draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_in_hs) begin
      r_s1_valid <= 1'b1;
      r_s1       <= '{a: i_ope1, b: i_ope2, op: i_opcode};
    end else if (w_adv2) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: result and flags only change on advance, so they hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o_valid <= 1'b0;
      r_out     <= '0;
    end else if (w_adv2) begin
      r_o_valid <= 1'b1;
      r_out     <= w_out;
    end else if (i_ready) begin
      r_o_valid <= 1'b0;
    end
  end

  assign o_valid  = r_o_valid;
  assign o_result = r_out.res;
  assign o_zero   = r_out.zero;
  assign o_neg    = r_out.neg;
  assign o_carry  = r_out.carry;
  assign o_ovf    = r_out.ovf;
  assign o_err    = r_out.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: the driver pushes expected responses when an
// input handshake is seen; a monitor compares every presented output.
module tb_alu_pipe;

  localparam int W  = 8;
  localparam int OW = 6;

  typedef struct packed {
    logic [W-1:0] res;
    logic zero, neg, carry, ovf, err;
  } exp_t;

  logic          clk, rst, i_valid, o_ready, o_valid, i_ready;
  logic [W-1:0]  i_ope1, i_ope2, o_result;
  logic [OW-1:0] i_opcode;
  logic          o_zero, o_neg, o_carry, o_ovf, o_err;

  alu_pipe #(.BUS_LEN(W), .OPCODE_LEN(OW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_ope1(i_ope1), .i_ope2(i_ope2), .i_opcode(i_opcode),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_zero(o_zero), .o_neg(o_neg), .o_carry(o_carry), .o_ovf(o_ovf), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100,
                         OR_ = 6'b100101, XOR_ = 6'b100110, NOR_ = 6'b100111,
                         SRA = 6'b000011, SRL = 6'b000010, SLL = 6'b000000,
                         SLT = 6'b101010, SLTU = 6'b101011;

  exp_t q[$];
  int   n_checks = 0, n_fail = 0, n_push = 0, n_pop = 0, n_acc = 0;
  bit   rnd_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model from the opcode rules, using plain integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] op);
    exp_t   e;
    longint ua, ub, sa, sb, r, s;
    int     sh;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    sh = int'(ub % W);
    e  = '0;
    r  = 0;
    case (op)
      ADD:  begin r = ua + ub; e.carry = (r >= (64'sd1 << W)); s = sa + sb;
                  e.ovf = (s > (64'sd1 << (W-1)) - 1) || (s < -(64'sd1 << (W-1))); end
      SUB:  begin r = ua - ub; e.carry = (ua < ub); s = sa - sb;
                  e.ovf = (s > (64'sd1 << (W-1)) - 1) || (s < -(64'sd1 << (W-1))); end
      AND_: r = ua & ub;
      OR_:  r = ua | ub;
      XOR_: r = ua ^ ub;
      NOR_: r = ~(ua | ub);
      SRA:  r = sa >>> sh;
      SRL:  r = ua >> sh;
      SLL:  r = ua << sh;
      SLT:  r = (sa < sb) ? 1 : 0;
      SLTU: r = (ua < ub) ? 1 : 0;
      default: begin r = 0; e.err = 1'b1; end
    endcase
    e.res  = r[W-1:0];
    e.zero = (e.res == 0);
    e.neg  = e.res[W-1];
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] r, input logic z, n, c, v, er);
    exp_t e;
    e = '{res: r, zero: z, neg: n, carry: c, ovf: v, err: er};
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_x(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] op, input exp_t e);
    int k;
    i_valid = 1'b1; i_ope1 = a; i_ope2 = b; i_opcode = op;
    k = 0;
    forever begin
      @(negedge clk);
      if (o_ready) break;
      k++;
      if (k > 200) begin
        chk("accept_timeout", 64'd0, 64'd1);
        i_valid = 1'b0;
        return;
      end
    end
    q.push_back(e); n_push++; n_acc++;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] op);
    send_x(a, b, op, model(a, b, op));
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 200 && q.size() != 0; k++) begin @(posedge clk); #1; end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic chk_latency();
    @(negedge clk); chk("lat_cycle1_valid", 64'(o_valid), 64'd0);
    @(negedge clk); chk("lat_cycle2_valid", 64'(o_valid), 64'd1);
    @(posedge clk); #1;
  endtask

  // Monitor: compare on drain, and check held contents while stalled.
  always @(negedge clk) begin
    exp_t act, e;
    if (!rst && o_valid) begin
      act = {o_result, o_zero, o_neg, o_carry, o_ovf, o_err};
      if (q.size() == 0) begin
        chk("unexpected_output", 64'(act), 64'hDEAD);
      end else if (i_ready) begin
        e = q.pop_front(); n_pop++;
        chk("out", 64'(act), 64'(e));
      end else begin
        chk("stall_hold", 64'(act), 64'(q[0]));
      end
    end
  end

  logic [5:0] ops [11] = '{ADD, SUB, AND_, OR_, XOR_, NOR_, SRA, SRL, SLL, SLT, SLTU};

  initial begin
    logic [5:0] op;
    int base;
    rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_ope1 = '0; i_ope2 = '0; i_opcode = '0;
    #2 rst = 1'b1;
    #2;
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_ready", 64'(o_ready), 64'd0);
    chk("rst_outputs", 64'({o_result, o_zero, o_neg, o_carry, o_ovf, o_err}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; i_ready = 1'b1;

    // Directed vectors with hand-computed expectations
    send_x(8'h7F, 8'h01, ADD, mk(8'h80, 0, 1, 0, 1, 0));
    chk_latency();
    send_x(8'h05, 8'h07, SUB, mk(8'hFE, 0, 1, 1, 0, 0));
    send_x(8'hFF, 8'h01, ADD, mk(8'h00, 1, 0, 1, 0, 0));
    send_x(8'h80, 8'h09, SRA, mk(8'hC0, 0, 1, 0, 0, 0));
    send_x(8'h80, 8'h01, SRL, mk(8'h40, 0, 0, 0, 0, 0));
    send_x(8'h81, 8'h01, SLL, mk(8'h02, 0, 0, 0, 0, 0));
    send_x(8'hFF, 8'h01, SLT, mk(8'h01, 0, 0, 0, 0, 0));
    send_x(8'hFF, 8'h01, SLTU, mk(8'h00, 1, 0, 0, 0, 0));
    send_x(8'h12, 8'h34, 6'b111111, mk(8'h00, 1, 0, 0, 0, 1));
    send_x(8'hF0, 8'h3C, AND_, mk(8'h30, 0, 0, 0, 0, 0));
    send_x(8'h80, 8'h01, SUB, mk(8'h7F, 0, 0, 0, 1, 0));
    drain();

    // Backpressure: 4 back-to-back ADDs into a stalled consumer
    i_ready = 1'b0;
    base = n_acc;
    fork
      begin
        for (int i = 0; i < 4; i++) send(8'(i * 37 + 3), 8'(i * 91 + 200), ADD);
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_o_ready_low", 64'(o_ready), 64'd0);
        chk("bp_accepts", 64'(n_acc - base), 64'd2);
        @(posedge clk); #1 i_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset mid-cycle with both stages full
    i_ready = 1'b0;
    send(8'h11, 8'h22, ADD);
    send(8'h33, 8'h44, XOR_);
    #3 rst = 1'b1;
    #1;
    chk("arst_o_valid", 64'(o_valid), 64'd0);
    chk("arst_o_ready", 64'(o_ready), 64'd0);
    chk("arst_outputs", 64'({o_result, o_zero, o_neg, o_carry, o_ovf, o_err}), 64'd0);
    q.delete(); n_push -= 2;
    @(posedge clk); #1 rst = 1'b0; i_ready = 1'b1;
    send(8'h40, 8'h40, ADD);
    chk_latency();
    drain();

    // Randomized traffic with random consumer backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
          else op = ops[$urandom_range(0, 10)];
          send(8'($urandom), 8'($urandom), op);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    i_ready = 1'b1;
    drain();
    chk("pop_count", 64'(n_pop), 64'(n_push));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
